// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: tracks EX/MEM/WB destinations,
// issues registered forwarding selects, and raises load-use stalls, flushes and memory waits.
module hazard_ctrl #(
   parameter int unsigned REG_BITS = 3,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rq,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic                id_uses_rq,
   input  logic                id_uses_rs,
   input  logic                id_wr_en,
   input  logic [REG_BITS-1:0] id_rd,
   input  logic                id_is_load,
   input  logic                ex_flush,
   input  logic                mem_ready,
   output logic                stall_if,
   output logic                stall_id,
   output logic                bubble_ex,
   output logic                flush_ifid,
   output logic [1:0]          fwd_rq,
   output logic [1:0]          fwd_rs,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt
);

   localparam logic [1:0] FwdReg = 2'b00;
   localparam logic [1:0] FwdEx  = 2'b01;
   localparam logic [1:0] FwdMem = 2'b10;

   logic                ex_v_q, mem_v_q, wb_v_q;
   logic [REG_BITS-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
   logic                ex_ld_q, mem_ld_q, wb_ld_q;
   logic [1:0]          fwd_rq_q, fwd_rs_q;
   logic [1:0]          fwd_rq_d, fwd_rs_d;
   logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

   logic rq_ex_hit, rs_ex_hit, rq_mem_hit, rs_mem_hit;
   logic load_use, flush_act, stall_evt, ex_entry_v;

   // Slots never hold r0, so a zero source index cannot produce a hit.
   assign rq_ex_hit  = id_uses_rq && (id_rq != '0) && ex_v_q  && (id_rq == ex_rd_q);
   assign rs_ex_hit  = id_uses_rs && (id_rs != '0) && ex_v_q  && (id_rs == ex_rd_q);
   assign rq_mem_hit = id_uses_rq && (id_rq != '0) && mem_v_q && (id_rq == mem_rd_q);
   assign rs_mem_hit = id_uses_rs && (id_rs != '0) && mem_v_q && (id_rs == mem_rd_q);

   assign load_use  = id_valid && ex_ld_q && (rq_ex_hit || rs_ex_hit);
   assign flush_act = rst_n && mem_ready && ex_flush;
   assign stall_evt = mem_ready && load_use && !flush_act;

   always_comb begin
      stall_if   = 1'b0;
      stall_id   = 1'b0;
      bubble_ex  = 1'b0;
      flush_ifid = 1'b0;
      if (!mem_ready) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
      end else if (flush_act) begin
         flush_ifid = 1'b1;
         bubble_ex  = 1'b1;
      end else if (load_use) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         bubble_ex = 1'b1;
      end
   end

   always_comb begin
      fwd_rq_d = FwdReg;
      fwd_rs_d = FwdReg;
      if (!bubble_ex && !flush_ifid) begin
         if (rq_ex_hit)       fwd_rq_d = FwdEx;
         else if (rq_mem_hit) fwd_rq_d = FwdMem;
         if (rs_ex_hit)       fwd_rs_d = FwdEx;
         else if (rs_mem_hit) fwd_rs_d = FwdMem;
      end
   end

   assign ex_entry_v = id_valid && id_wr_en && (id_rd != '0) && !bubble_ex && !flush_ifid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_v_q      <= 1'b0;
         ex_rd_q     <= '0;
         ex_ld_q     <= 1'b0;
         mem_v_q     <= 1'b0;
         mem_rd_q    <= '0;
         mem_ld_q    <= 1'b0;
         wb_v_q      <= 1'b0;
         wb_rd_q     <= '0;
         wb_ld_q     <= 1'b0;
         fwd_rq_q    <= FwdReg;
         fwd_rs_q    <= FwdReg;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (mem_ready) begin
         wb_v_q   <= mem_v_q;
         wb_rd_q  <= mem_rd_q;
         wb_ld_q  <= mem_ld_q;
         mem_v_q  <= ex_v_q;
         mem_rd_q <= ex_rd_q;
         mem_ld_q <= ex_ld_q;
         ex_v_q   <= ex_entry_v;
         ex_rd_q  <= ex_entry_v ? id_rd : '0;
         ex_ld_q  <= ex_entry_v && id_is_load;
         fwd_rq_q <= fwd_rq_d;
         fwd_rs_q <= fwd_rs_d;
         if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (flush_act && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign fwd_rq    = fwd_rq_q;
   assign fwd_rs    = fwd_rs_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   // WB slot is kept for completeness of the scoreboard; nothing forwards from it.
   logic unused_wb;
   assign unused_wb = ^{wb_v_q, wb_rd_q, wb_ld_q};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: forwarding, load-use, flush, memory wait, reset.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [2:0]  id_rq, id_rs, id_rd;
   logic        id_uses_rq, id_uses_rs, id_wr_en, id_is_load;
   logic        ex_flush, mem_ready;
   logic        stall_if, stall_id, bubble_ex, flush_ifid;
   logic [1:0]  fwd_rq, fwd_rs;
   logic [15:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   hazard_ctrl #(.REG_BITS(3), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_rq      (id_rq),
      .id_rs      (id_rs),
      .id_uses_rq (id_uses_rq),
      .id_uses_rs (id_uses_rs),
      .id_wr_en   (id_wr_en),
      .id_rd      (id_rd),
      .id_is_load (id_is_load),
      .ex_flush   (ex_flush),
      .mem_ready  (mem_ready),
      .stall_if   (stall_if),
      .stall_id   (stall_id),
      .bubble_ex  (bubble_ex),
      .flush_ifid (flush_ifid),
      .fwd_rq     (fwd_rq),
      .fwd_rs     (fwd_rs),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Drive the ID stage; rq/rs index of 0 with use=0 means that operand is not read.
   task automatic id_set(input logic v, input logic wr, input logic [2:0] rd, input logic ld,
                         input logic urq, input logic [2:0] rq,
                         input logic urs, input logic [2:0] rs);
      id_valid   = v;
      id_wr_en   = wr;
      id_rd      = rd;
      id_is_load = ld;
      id_uses_rq = urq;
      id_rq      = rq;
      id_uses_rs = urs;
      id_rs      = rs;
      #1;
   endtask

   task automatic nop();
      id_set(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      ex_flush  = 1'b0;
      mem_ready = 1'b0;
      nop();
      // Reset state
      check("rst_fwd_rq", 32'(fwd_rq), 32'd0);
      check("rst_fwd_rs", 32'(fwd_rs), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      check("rst_memwait_stall", 32'(stall_if), 32'd1);
      check("rst_bubble", 32'(bubble_ex), 32'd0);
      mem_ready = 1'b1;
      step();
      rst_n = 1'b1;

      // Back-to-back ALU: ADD r1,r2,r3 ; SUB r2,r1,r3
      id_set(1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd3);
      step();
      id_set(1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 3'd1, 1'b1, 3'd3);
      check("b2b_no_stall", 32'(stall_if), 32'd0);
      check("b2b_no_bubble", 32'(bubble_ex), 32'd0);
      step();
      nop();
      check("b2b_fwd_rq", 32'(fwd_rq), 32'd1);
      check("b2b_fwd_rs", 32'(fwd_rs), 32'd0);
      check("b2b_stall_cnt", 32'(stall_cnt), 32'd0);

      // Distance-2: ADD r1,r6,r7 ; NOP ; OR r4,r5,r1
      id_set(1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 3'd6, 1'b1, 3'd7);
      step();
      nop();
      step();
      id_set(1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 3'd5, 1'b1, 3'd1);
      step();
      nop();
      check("d2_fwd_rs", 32'(fwd_rs), 32'd2);
      check("d2_fwd_rq", 32'(fwd_rq), 32'd0);

      // Load-use: LD r2,(r6) ; ADD r3,r2,r2
      id_set(1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd6, 1'b0, 3'd0);
      step();
      id_set(1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2);
      check("lu_stall_if", 32'(stall_if), 32'd1);
      check("lu_stall_id", 32'(stall_id), 32'd1);
      check("lu_bubble", 32'(bubble_ex), 32'd1);
      check("lu_no_flush", 32'(flush_ifid), 32'd0);
      step();
      check("lu_one_cycle", 32'(stall_if), 32'd0);
      check("lu_bubble_clr", 32'(bubble_ex), 32'd0);
      check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      check("lu_fwd_bubble", 32'(fwd_rq), 32'd0);
      step();
      nop();
      check("lu_fwd_rq", 32'(fwd_rq), 32'd2);
      check("lu_fwd_rs", 32'(fwd_rs), 32'd2);

      // Flush beats load-use: LD r5 ; ADD r6,r5 with ex_flush
      id_set(1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0);
      step();
      ex_flush = 1'b1;
      id_set(1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 3'd5, 1'b0, 3'd0);
      check("fl_flush_ifid", 32'(flush_ifid), 32'd1);
      check("fl_bubble", 32'(bubble_ex), 32'd1);
      check("fl_stall_if", 32'(stall_if), 32'd0);
      check("fl_stall_id", 32'(stall_id), 32'd0);
      step();
      ex_flush = 1'b0;
      id_set(1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 3'd6, 1'b1, 3'd6);
      check("fl_flush_cnt", 32'(flush_cnt), 32'd1);
      check("fl_stall_cnt", 32'(stall_cnt), 32'd1);
      check("fl_after_no_stall", 32'(stall_if), 32'd0);
      step();
      check("fl_untracked_rq", 32'(fwd_rq), 32'd0);
      check("fl_untracked_rs", 32'(fwd_rs), 32'd0);

      // Memory wait with pending flush; EX holds SUB r7
      id_set(1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 3'd7, 1'b0, 3'd0);
      step();
      check("mw_pre_fwd_rq", 32'(fwd_rq), 32'd1);
      mem_ready = 1'b0;
      ex_flush  = 1'b1;
      id_set(1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 3'd1, 1'b1, 3'd7);
      for (int i = 0; i < 3; i++) begin
         check("mw_stall_if", 32'(stall_if), 32'd1);
         check("mw_no_flush", 32'(flush_ifid), 32'd0);
         check("mw_no_bubble", 32'(bubble_ex), 32'd0);
         step();
         check("mw_fwd_hold", 32'(fwd_rq), 32'd1);
      end
      check("mw_flush_cnt_hold", 32'(flush_cnt), 32'd1);
      mem_ready = 1'b1;
      #1;
      check("mw_flush_act", 32'(flush_ifid), 32'd1);
      check("mw_release_stall", 32'(stall_if), 32'd0);
      step();
      ex_flush = 1'b0;
      nop();
      check("mw_flush_cnt", 32'(flush_cnt), 32'd2);
      check("mw_fwd_cleared", 32'(fwd_rq), 32'd0);

      // r0 destination: LD r0 ; ADD r1,r0,r0 -> no stall, no forwarding
      id_set(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 3'd6, 1'b0, 3'd0);
      step();
      id_set(1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0);
      check("r0_no_stall", 32'(stall_if), 32'd0);
      step();
      nop();
      check("r0_fwd_rq", 32'(fwd_rq), 32'd0);
      check("r0_fwd_rs", 32'(fwd_rs), 32'd0);

      // Reset mid-stall: LD r3 ; ADD r4,r3 then pull rst_n
      id_set(1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd6, 1'b0, 3'd0);
      step();
      id_set(1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3);
      check("rs_pre_bubble", 32'(bubble_ex), 32'd1);
      check("rs_pre_stall_cnt", 32'(stall_cnt), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rs_bubble_drop", 32'(bubble_ex), 32'd0);
      check("rs_fwd_rq", 32'(fwd_rq), 32'd0);
      check("rs_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rs_flush_cnt", 32'(flush_cnt), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("rs_post_bubble", 32'(bubble_ex), 32'd0);
      step();
      nop();
      check("rs_post_fwd_rq", 32'(fwd_rq), 32'd0);
      check("rs_post_fwd_rs", 32'(fwd_rs), 32'd0);
      check("rs_post_stall_cnt", 32'(stall_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
